boss_health_ctl: RTL and testbench

Boss health and damage bookkeeping for the play screen. Consumes the single-cycle hit pulses from the archer projectile and melee attack stages and applies damage with saturating subtraction, a per-hit invulnerability window and a hit-flash window. Runs a death sequence and produces `boss_alive`, which feeds back into the projectile stages' collision gating. Also drives the boss renderer (`boss_hit_flash`, `boss_dying`) and the game-state FSM (`boss_defeated`).

---
 rtl/boss_health_ctl.sv | 125 ++++++++++++
 tb/tb_boss_health_ctl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/boss_health_ctl.sv
// Boss HP bookkeeping: saturating damage, invulnerability/flash windows, death sequence.
// Hits are sampled every cycle with no buffering; all outputs are registered (one-cycle latency).
module boss_health_ctl #(
  parameter int MAX_HP        = 100,
  parameter int ARCHER_DAMAGE = 5,
  parameter int MELEE_DAMAGE  = 10,
  parameter int INVULN_FRAMES = 6,
  parameter int FLASH_FRAMES  = 4,
  parameter int DEATH_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] game_active,
  input  logic       attack_hit,
  input  logic       melee_hit,
  output logic [7:0] boss_hp,
  output logic       boss_alive,
  output logic       boss_hit_flash,
  output logic       boss_dying,
  output logic       boss_defeated,
  output logic       hit_accepted
);

  localparam int CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_ALIVE, S_DYING, S_DEAD} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_hp, w_hp_nxt, w_hp_hit;
  logic [CW-1:0]   r_invuln, r_flash, r_death;
  logic [CW-1:0]   w_invuln_nxt, w_flash_nxt, w_death_nxt;
  logic [8:0]      w_dmg;
  logic            w_accept, w_defeat_nxt;
  logic            r_alive, r_flash_o, r_dying, r_defeated, r_accepted;

  assign w_accept = (r_state == S_ALIVE) && (game_active == 2'd1) &&
                    (r_invuln == '0) && (attack_hit || melee_hit);
  assign w_dmg    = (attack_hit ? 9'(ARCHER_DAMAGE) : 9'd0) +
                    (melee_hit  ? 9'(MELEE_DAMAGE)  : 9'd0);
  // Saturate rather than wrap when the hit overkills the remaining HP.
  assign w_hp_hit = (w_dmg >= {1'b0, r_hp}) ? 8'd0 : (r_hp - w_dmg[7:0]);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (game_active == 2'd0) begin
      w_state_nxt = S_IDLE;
    end else if (game_active == 2'd1) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ALIVE;
        S_ALIVE: if (w_accept && w_hp_hit == 8'd0) w_state_nxt = S_DYING;
        S_DYING: if (r_death == '0) w_state_nxt = S_DEAD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_hp_nxt     = r_hp;
    w_invuln_nxt = r_invuln;
    w_flash_nxt  = r_flash;
    w_death_nxt  = r_death;
    w_defeat_nxt = 1'b0;
    if (game_active == 2'd0) begin
      w_hp_nxt     = 8'(MAX_HP);
      w_invuln_nxt = '0;
      w_flash_nxt  = '0;
      w_death_nxt  = '0;
    end else if (game_active == 2'd1) begin
      if (frame_tick && r_invuln != '0) w_invuln_nxt = r_invuln - CW'(1);
      if (frame_tick && r_flash  != '0) w_flash_nxt  = r_flash  - CW'(1);
      if (frame_tick && r_death  != '0) w_death_nxt  = r_death  - CW'(1);
      if (r_state == S_IDLE) begin
        w_hp_nxt     = 8'(MAX_HP);
        w_invuln_nxt = '0;
        w_flash_nxt  = '0;
        w_death_nxt  = '0;
      end else if (w_accept) begin
        // Reloads take priority over a coincident frame tick.
        w_hp_nxt     = w_hp_hit;
        w_invuln_nxt = CW'(INVULN_FRAMES);
        w_flash_nxt  = CW'(FLASH_FRAMES);
        if (w_hp_hit == 8'd0) w_death_nxt = CW'(DEATH_FRAMES);
      end
      if (r_state == S_DYING && r_death == '0) w_defeat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hp       <= 8'(MAX_HP);
      r_invuln   <= '0;
      r_flash    <= '0;
      r_death    <= '0;
      r_alive    <= 1'b0;
      r_flash_o  <= 1'b0;
      r_dying    <= 1'b0;
      r_defeated <= 1'b0;
      r_accepted <= 1'b0;
    end else begin
      r_hp       <= w_hp_nxt;
      r_invuln   <= w_invuln_nxt;
      r_flash    <= w_flash_nxt;
      r_death    <= w_death_nxt;
      r_alive    <= (w_state_nxt == S_ALIVE);
      r_flash_o  <= (w_flash_nxt != '0);
      r_dying    <= (w_state_nxt == S_DYING);
      r_defeated <= w_defeat_nxt;
      r_accepted <= w_accept;
    end
  end

  assign boss_hp        = r_hp;
  assign boss_alive     = r_alive;
  assign boss_hit_flash = r_flash_o;
  assign boss_dying     = r_dying;
  assign boss_defeated  = r_defeated;
  assign hit_accepted   = r_accepted;

endmodule

// File: tb/tb_boss_health_ctl.sv
// Random and directed stimulus against a frame-level behavioural model; a monitor
// compares every registered output one edge after each stimulus cycle.
module tb_boss_health_ctl;

  localparam int MAX = 100, ADMG = 5, MDMG = 10, INV = 6, FL = 4, DTH = 60;
  localparam int P_IDLE = 0, P_ALIVE = 1, P_DYING = 2, P_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] game_active = 2'd0;
  logic       attack_hit = 1'b0, melee_hit = 1'b0;
  logic [7:0] boss_hp;
  logic       boss_alive, boss_hit_flash, boss_dying, boss_defeated, hit_accepted;

  boss_health_ctl #(.MAX_HP(MAX), .ARCHER_DAMAGE(ADMG), .MELEE_DAMAGE(MDMG),
                    .INVULN_FRAMES(INV), .FLASH_FRAMES(FL), .DEATH_FRAMES(DTH)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
    .attack_hit(attack_hit), .melee_hit(melee_hit), .boss_hp(boss_hp),
    .boss_alive(boss_alive), .boss_hit_flash(boss_hit_flash), .boss_dying(boss_dying),
    .boss_defeated(boss_defeated), .hit_accepted(hit_accepted));

  always #5 clk = ~clk;

  typedef struct {
    int hp;
    bit alive, dying, flash, defeated, accepted;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0;

  // Reference: boss life tracked in frames, HP as plain integer arithmetic.
  int m_ph = P_IDLE, m_hp = MAX, m_inv = 0, m_fl = 0, m_dth = 0;

  task automatic model(input bit r, input logic [1:0] ga, input bit t, input bit a, input bit m);
    exp_t e;
    bit   acc, dfd;
    int   dmg, d0;
    acc = 0;
    dfd = 0;
    if (!r || ga == 2'd0) begin
      m_ph = P_IDLE; m_hp = MAX; m_inv = 0; m_fl = 0; m_dth = 0;
    end else if (ga == 2'd1) begin
      d0 = m_dth;
      if (m_ph == P_IDLE) begin
        m_ph = P_ALIVE; m_hp = MAX; m_inv = 0; m_fl = 0; m_dth = 0;
      end else begin
        bit vulnerable;
        vulnerable = (m_inv == 0);
        if (t) begin
          m_inv = (m_inv > 0) ? m_inv - 1 : 0;
          m_fl  = (m_fl  > 0) ? m_fl  - 1 : 0;
          m_dth = (m_dth > 0) ? m_dth - 1 : 0;
        end
        if (m_ph == P_ALIVE && vulnerable && (a || m)) begin
          dmg  = (a ? ADMG : 0) + (m ? MDMG : 0);
          m_hp = (dmg >= m_hp) ? 0 : m_hp - dmg;
          m_inv = INV; m_fl = FL; acc = 1;
          if (m_hp == 0) begin m_ph = P_DYING; m_dth = DTH; end
        end else if (m_ph == P_DYING && d0 == 0) begin
          m_ph = P_DEAD; dfd = 1;
        end
      end
    end
    e.hp = m_hp; e.alive = (m_ph == P_ALIVE); e.dying = (m_ph == P_DYING);
    e.flash = (m_fl != 0); e.defeated = dfd; e.accepted = acc;
    q.push_back(e);
  endtask

  task automatic cyc(input bit r, input logic [1:0] ga, input bit t, input bit a, input bit m);
    @(negedge clk);
    rst = r; game_active = ga; frame_tick = t; attack_hit = a; melee_hit = m;
    model(r, ga, t, a, m);
  endtask

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        chk("boss_hp",        {1'b0, boss_hp},        9'(e.hp));
        chk("boss_alive",     {8'd0, boss_alive},     {8'd0, e.alive});
        chk("boss_dying",     {8'd0, boss_dying},     {8'd0, e.dying});
        chk("boss_hit_flash", {8'd0, boss_hit_flash}, {8'd0, e.flash});
        chk("boss_defeated",  {8'd0, boss_defeated},  {8'd0, e.defeated});
        chk("hit_accepted",   {8'd0, hit_accepted},   {8'd0, e.accepted});
      end
    end
  end

  initial begin : stim
    int len, pick, guard;
    logic [1:0] ga;
    bit r;
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);                                 // first hit: 100 -> 95
    for (int i = 0; i < 3; i++) begin cyc(1, 1, 1, 1, 0); cyc(1, 1, 0, 0, 0); end
    for (int i = 0; i < 4; i++) cyc(1, 2, 1, 1, 1);     // paused: frozen, hits dropped
    cyc(1, 1, 0, 1, 0);                                 // still invulnerable after resume
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 1);                                 // both hits: -15
    guard = 0;
    while (m_ph == P_ALIVE && guard < 500) begin cyc(1, 1, 1, 0, 1); guard++; end
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 1, 1);    // dying: hits dropped
    cyc(0, 1, 0, 1, 0);                                 // reset mid-death
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 1);                                 // simultaneous at full HP -> 85
    guard = 0;
    while (m_ph != P_DEAD && guard < 2000) begin cyc(1, 1, 1, 1, 0); guard++; end
    repeat (3) cyc(1, 1, 0, 1, 1);
    repeat (2) cyc(1, 0, 0, 0, 0);                      // DEAD -> IDLE
    for (int s = 0; s < 250; s++) begin
      len  = $urandom_range(5, 40);
      pick = $urandom_range(0, 99);
      ga   = (pick < 84) ? 2'd1 : (pick < 96) ? 2'($urandom_range(2, 3)) : 2'd0;
      r    = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < len; k++)
        cyc((k == 0) ? r : 1'b1, ga, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    guard = 0;
    while (q.size() != 0 && guard < 10) begin @(posedge clk); #2; guard++; end
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
